// File: rtl/tft_pkg.sv
// Shared definitions for the TFT panel timing controller: FSM encoding,
// counter/coordinate widths and the default 480x272 panel timing.
package tft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tft_state_e;

    // Default 480x272 timing (clocks horizontally, lines vertically)
    localparam int DEF_H_SYNC  = 41;
    localparam int DEF_H_BACK  = 2;
    localparam int DEF_H_VALID = 480;
    localparam int DEF_H_FRONT = 2;
    localparam int DEF_V_SYNC  = 10;
    localparam int DEF_V_BACK  = 2;
    localparam int DEF_V_VALID = 272;
    localparam int DEF_V_FRONT = 2;

    localparam int CNT_W = 12;
    localparam int PIX_W = 10;
    localparam logic [PIX_W-1:0] PIX_NONE = 10'h3FF;

    function automatic logic [CNT_W-1:0] to_cnt(input int value);
        return CNT_W'(value);
    endfunction

endpackage

// File: rtl/tft_delay_line.sv
// Fixed-depth register delay line with a reset value; depth 0 is a plain wire.
module tft_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = clk ^ srst;
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (srst) begin
                    stage_q[gi] <= RST_VAL;
                end else begin
                    stage_q[gi] <= stage_d[gi];
                end
            end
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/tft_disp_ctrl.sv
// TFT panel timing controller: frame counters, pixel request window and
// sync/DE/RGB outputs aligned to a source with PIX_LAT clocks of latency.
module tft_disp_ctrl
    import tft_pkg::*;
#(
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   H_VALID  = DEF_H_VALID,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter int   V_VALID  = DEF_V_VALID,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter int   RGB_W    = 16,
    parameter int   PIX_LAT  = 1,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             disp_en,
    input  logic [RGB_W-1:0] pix_data,
    output logic [9:0]       pix_x,
    output logic [9:0]       pix_y,
    output logic [RGB_W-1:0] rgb,
    output logic             hsync,
    output logic             vsync,
    output logic             tft_de,
    output logic             tft_bl,
    output logic             frame_start,
    output logic             busy
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST_C  = to_cnt(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C  = to_cnt(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C  = to_cnt(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C  = to_cnt(V_SYNC);
    localparam logic [CNT_W-1:0] H_START_C = to_cnt(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] V_START_C = to_cnt(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] H_END_C   = to_cnt(H_TOTAL - H_FRONT - 1);
    localparam logic [CNT_W-1:0] V_END_C   = to_cnt(V_TOTAL - V_FRONT - 1);

    // Delayed bus layout: {first_pixel, de, vsync, hsync}
    localparam logic [3:0] DLY_IDLE = {1'b0, 1'b0, ~SYNC_POL, ~SYNC_POL};

    tft_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
    logic [CNT_W-1:0] cnt_v_q, cnt_v_d;
    logic             run_act;
    logic             h_last, v_last, frame_last;
    logic             req_win;
    logic [3:0]       raw_bus, dly_bus;

    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             tft_de_q, tft_de_d;
    logic             tft_bl_q, tft_bl_d;
    logic             frame_start_q, frame_start_d;

    assign h_last     = (cnt_h_q == H_LAST_C);
    assign v_last     = (cnt_v_q == V_LAST_C);
    assign frame_last = h_last && v_last;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A re-raised enable during DRAIN wins over the end-of-frame exit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (disp_en) state_d = ST_RUN;
            ST_RUN:   if (!disp_en) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (disp_en) begin
                    state_d = ST_RUN;
                end else if (frame_last) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        run_act = (state_q != ST_IDLE);
        busy    = run_act;
    end

    // Counters are parked at zero in IDLE so the next RUN begins a whole frame.
    always_comb begin
        cnt_h_d = cnt_h_q;
        cnt_v_d = cnt_v_q;
        if (!run_act) begin
            cnt_h_d = '0;
            cnt_v_d = '0;
        end else if (h_last) begin
            cnt_h_d = '0;
            cnt_v_d = v_last ? '0 : cnt_v_q + 1'b1;
        end else begin
            cnt_h_d = cnt_h_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_h_q <= '0;
            cnt_v_q <= '0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    always_comb begin
        req_win = run_act
                  && (cnt_h_q >= H_START_C) && (cnt_h_q <= H_END_C)
                  && (cnt_v_q >= V_START_C) && (cnt_v_q <= V_END_C);
        pix_x = PIX_NONE;
        pix_y = PIX_NONE;
        if (req_win) begin
            pix_x = PIX_W'(cnt_h_q - H_START_C);
            pix_y = PIX_W'(cnt_v_q - V_START_C);
        end
        raw_bus[0] = (run_act && (cnt_h_q < H_SYNC_C)) ? SYNC_POL : ~SYNC_POL;
        raw_bus[1] = (run_act && (cnt_v_q < V_SYNC_C)) ? SYNC_POL : ~SYNC_POL;
        raw_bus[2] = req_win;
        raw_bus[3] = run_act && (cnt_h_q == H_START_C) && (cnt_v_q == V_START_C);
    end

    // Matches the source latency so timing lines up with the returned pixel.
    tft_delay_line #(
        .WIDTH   (4),
        .DEPTH   (PIX_LAT),
        .RST_VAL (DLY_IDLE)
    ) u_dly (
        .clk  (sys_clk),
        .srst (sys_rst),
        .d    (raw_bus),
        .q    (dly_bus)
    );

    always_comb begin
        hsync_d       = dly_bus[0];
        vsync_d       = dly_bus[1];
        tft_de_d      = dly_bus[2];
        frame_start_d = dly_bus[3];
        rgb_d         = dly_bus[2] ? pix_data : '0;
        tft_bl_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rgb_q         <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            tft_de_q      <= 1'b0;
            tft_bl_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            tft_de_q      <= tft_de_d;
            tft_bl_q      <= tft_bl_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign rgb         = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign tft_de      = tft_de_q;
    assign tft_bl      = tft_bl_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/tft_disp_ctrl.md
TFT_DISP_CTRL -- requirements
Module: tft_disp_ctrl

Interface
REQ-001 The block SHALL have parameter H_SYNC, default 41, horizontal sync width in clocks.
REQ-002 The block SHALL have parameter H_BACK, default 2, horizontal back porch in clocks.
REQ-003 The block SHALL have parameter H_VALID, default 480, active pixels per line.
REQ-004 The block SHALL have parameter H_FRONT, default 2, horizontal front porch in clocks.
REQ-005 The block SHALL have parameters V_SYNC / V_BACK / V_VALID / V_FRONT, defaults 10 / 2 / 272 / 2, vertical timing in lines.
REQ-006 The block SHALL have parameter RGB_W, default 16, pixel bus width.
REQ-007 The block SHALL have parameter PIX_LAT, default 1, range 0..3, clocks from pix_x/pix_y request to valid pix_data.
REQ-008 The block SHALL have parameter SYNC_POL, default 1, active level of hsync/vsync.
REQ-009 sys_clk  in  1  pixel clock; the block has one clock.
REQ-010 sys_rst  in  1  reset, synchronous and active-high.
REQ-011 disp_en  in  1  display enable request.
REQ-012 pix_data  in  RGB_W  pixel from source, valid PIX_LAT clocks after its request.
REQ-013 pix_x, pix_y  out  10 each  request coordinates; 10'h3FF outside the request window.
REQ-014 rgb  out  RGB_W  pixel to panel; 0 outside the active area.
REQ-015 hsync, vsync, tft_de  out  1 each  panel timing, aligned with rgb.
REQ-016 tft_bl  out  1  backlight enable.
REQ-017 frame_start  out  1  one-clock pulse on the first tft_de of each frame.
REQ-018 busy  out  1  high in RUN or DRAIN.

Function
REQ-019 H_TOTAL SHALL be H_SYNC+H_BACK+H_VALID+H_FRONT, and V_TOTAL the vertical equivalent; both are derived, not passed in.
- cnt_h wraps at H_TOTAL-1.
- cnt_v increments on the cnt_h wrap and wraps at V_TOTAL-1.
REQ-020 The FSM SHALL have states IDLE, RUN and DRAIN.
- IDLE->RUN: disp_en=1.
- RUN->DRAIN: disp_en=0.
- DRAIN->RUN: disp_en=1.
- DRAIN->IDLE: on the last clock of the frame (cnt_h=H_TOTAL-1 and cnt_v=V_TOTAL-1).
REQ-021 In IDLE, the counters SHALL hold 0, sync outputs SHALL sit at the inactive level, and tft_de, rgb and tft_bl SHALL be 0.
REQ-022 On entering RUN from IDLE, counting SHALL start at cnt_h=cnt_v=0, so every frame is complete.
REQ-023 The request window SHALL be cnt_h in [H_SYNC+H_BACK, H_TOTAL-H_FRONT-1] and cnt_v in [V_SYNC+V_BACK, V_TOTAL-V_FRONT-1], while in RUN or DRAIN.
- Inside the window, pix_x = cnt_h-(H_SYNC+H_BACK) and pix_y = cnt_v-(V_SYNC+V_BACK), combinational from the counters.
REQ-024 Raw hsync/vsync/de SHALL be delayed through a PIX_LAT-deep shift register and then one output register; outputs lag the counters by PIX_LAT+1 clocks.
REQ-025 rgb SHALL be registered as pix_data when the delayed de is 1, else 0, in the same output register stage as tft_de.
REQ-026 hsync SHALL equal SYNC_POL while the delayed cnt_h < H_SYNC; vsync likewise for cnt_v < V_SYNC.
REQ-027 tft_bl SHALL be registered high in RUN and DRAIN and low in IDLE.
REQ-028 The delay pipeline SHALL keep running in IDLE, so the last frame's tail flushes with correct alignment.
REQ-029 disp_en toggling within one frame SHALL never truncate a frame or restart the counters mid-frame.

Reset
REQ-030 On a sys_rst clock, FSM=IDLE, counters=0, the delay pipeline is cleared to inactive, and the outputs are: rgb=0, tft_de=0, tft_bl=0, frame_start=0, busy=0, hsync=vsync=~SYNC_POL.
REQ-031 sys_rst asserted mid-frame SHALL take priority over all other conditions; the next RUN starts a fresh frame.

Structure
REQ-032 A package tft_pkg SHALL hold the FSM state encoding and the default 480x272 timing constants.
REQ-033 The delay line SHALL be a sub-module tft_delay_line, parametrised in width and depth, with depth 0 meaning a wire.

Verification (sim params H 2/1/4/1, V 1/1/3/1, PIX_LAT=1, SYNC_POL=1, RGB_W=8)
REQ-034 Reset, then disp_en=1 -> busy=1 next clock; tft_bl=1; first hsync=1 two clocks after entering RUN; the frame is 8x6 clocks.
REQ-035 Source returns pix_data={pix_y[3:0],pix_x[3:0]} one clock late -> rgb shows 8'h00..8'h03 on line 0 and 8'h20..8'h23 on line 2; tft_de high for 4 clocks per active line.
REQ-036 disp_en=0 at cnt_v=2 -> frame completes; FSM goes IDLE after cnt_h=7 and cnt_v=5; tft_bl=0; outputs flush, then stay idle.
REQ-037 disp_en dropped and re-raised within DRAIN -> no gap; frame_start pulses every 48 clocks.
REQ-038 sys_rst for 1 clock at cnt_h=3, cnt_v=3 -> all outputs at reset values next clock; re-enable gives a full frame from cnt 0.
REQ-039 Run with PIX_LAT=0 and SYNC_POL=0 -> hsync low during sync; rgb aligned 1 clock after request.
